axi_rd_burst_ctrl: RTL
======================

// Module: axi_rd_burst_ctrl
// PURPOSE
//  AXI4 read-master sequencer. Accepts one AxiMasterRdCtrl_t job (start address and byte count) and splits it
//  into INCR bursts that never cross a 4 KB boundary and never exceed MAX_BEATS.
//  Drives AR, forwards R data to a downstream stream, and reports one AxiMasterRdStatus_t per job.
//  Sits between the frame-fetch logic and the AXI interconnect. Only one burst is outstanding at a time.
// PARAMETERS
//  DATA_W     64   R data width in bits (8..1024, power of 2); BEAT_BYTES = DATA_W/8; ARSIZE = log2(BEAT_BYTES)
//  MAX_BEATS  256  max beats per burst (1..256); ARLEN = beats-1
//  CACHE      4'b0011  constant ARCACHE value (AxiCache_t: Bufferable, Cacheable)
// PORTS
//  clk_i           in   1       clock
//  rst_i           in   1       synchronous reset, active-high
//  ctrl_valid_i    in   1       job request valid
//  ctrl_ready_o    out  1       job accepted when valid&ready
//  ctrl_i          in   48      AxiMasterRdCtrl_t {address, bytes}
//  status_valid_o  out  1       1-cycle pulse: job finished
//  status_o        out  2       AxiMasterRdStatus_t, held until next pulse
//  araddr_o        out  32      burst start address
//  arlen_o         out  8       beats-1
//  arsize_o        out  3       AxiSize_t, constant
//  arburst_o       out  2       AxiBurst_t INCR, constant
//  arcache_o       out  4       CACHE
//  arvalid_o       out  1       AR valid
//  arready_i       in   1       AR ready
//  rdata_i         in   DATA_W  read data
//  rresp_i         in   2       AxiResp_t
//  rlast_i         in   1       last beat flag
//  rvalid_i        in   1       R valid
//  rready_o        out  1       R ready
//  data_o          out  DATA_W  rdata_i passthrough (combinational)
//  data_valid_o    out  1       rvalid_i & state==R
//  data_ready_i    in   1       downstream ready; rready_o = data_ready_i & state==R
// BEHAVIOUR
//  Reset values:
//   - arvalid_o=0, status_valid_o=0, status_o=OKAY, state=IDLE.
//   - ctrl_ready_o=1 (asserted only in IDLE).
//   - rready_o=0 and data_valid_o=0 (both forced 0 outside R).
//  FSM IDLE->CALC->AR->R->(CALC|DONE)->IDLE.
//   - IDLE: on valid&ready, latch addr and total = ceil(bytes/BEAT_BYTES) beats; clear err.
//   - IDLE exits: unaligned addr -> DONE with SLVERR, no AR issued; bytes==0 -> DONE with OKAY, no AR issued.
//   - CALC: beats = min(remaining, MAX_BEATS, (4096 - addr[11:0]) / BEAT_BYTES).
//     Register arlen and araddr, then go to AR.
//   - AR: arvalid_o=1. All AR outputs stay stable until arready_i; transfer -> R.
//   - R: each rvalid&rready beat increments beat_cnt (9 bit).
//   - R exit: the beat where beat_cnt == arlen ends the burst regardless of rlast_i.
//     Then addr += beats*BEAT_BYTES and remaining -= beats; remaining==0 -> DONE, else CALC.
//   - DONE: status_valid_o=1 for exactly one cycle; status_o = accumulated resp; next state IDLE.
//  Response accumulation, worst-case priority DECERR > SLVERR > OKAY:
//   - EXOKAY counts as OKAY.
//   - rlast_i asserted before the final beat, or missing on the final beat -> SLVERR.
//   - An error does not abort the job; all bursts complete.
//  Latency: ctrl handshake to first arvalid_o = 2 cycles (IDLE->CALC->AR). Burst end to next arvalid_o = 2 cycles.
//  Widths: remaining and total are 17 bit; addr arithmetic is 32 bit. Wrap past 0xFFFF_FFFF is not checked; caller guarantees none.
//  rst_i mid-job: immediate return to IDLE; no status pulse; in-flight R beats after reset are not acknowledged.
//  ctrl_valid_i while busy: ignored (ctrl_ready_o=0).
// STRUCTURE
//  axi_pkg gains:
//   - AxiRdState_t enum {IDLE, CALC, AR, R, DONE}.
//   - constant AXI_4KB = 4096.
//   - function axiWorstResp(AxiResp_t a, AxiResp_t b).
//   - function beatsTo4k(addr, AxiSize_t).
//  Existing AxiSize_t, AxiBurst_t, AxiResp_t, AxiCache_t and AxiMasterRd* types are reused.
//  Single flat module; burst-split arithmetic is kept in a combinational always block, not a sub-module.
// TESTING (DATA_W=64, MAX_BEATS=256)
//  1. addr 0x1000, bytes 64 -> one AR araddr=0x1000 arlen=7 arsize=SIZE_8 INCR; 8 beats; status OKAY pulse.
//  2. addr 0x0FF0, bytes 64 -> AR 0x0FF0 len 1, then AR 0x1000 len 5; 8 beats total; OKAY.
//  3. addr 0x0, bytes 4096 -> AR 0x0 len 255 and AR 0x800 len 255; 512 beats; OKAY.
//  4. bytes 0 -> status_valid_o 2 cycles after accept, OKAY, no arvalid_o. addr 0x1004 -> SLVERR, no arvalid_o.
//  5. bytes 20 -> arlen=2 (ceil). Beat 2 rresp=SLVERR, beat 1 DECERR -> status DECERR after all 3 beats.
//     Same job with early rlast on beat 1 -> SLVERR.
//  6. data_ready_i toggled randomly and arready_i delayed 5 cycles -> AR stable while waiting, no lost beats.
//     rst_i during R -> outputs at reset values next cycle; new job runs clean.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 types and helpers for the read-burst sequencer.
package axi_pkg;

  typedef enum logic [2:0] {
    Size1, Size2, Size4, Size8, Size16, Size32, Size64, Size128
  } AxiSize_t;

  typedef enum logic [1:0] {
    BurstFixed, BurstIncr, BurstWrap, BurstRsvd
  } AxiBurst_t;

  typedef enum logic [1:0] {
    RespOkay, RespExokay, RespSlverr, RespDecerr
  } AxiResp_t;

  typedef logic [3:0] AxiCache_t;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] bytes;
  } AxiMasterRdCtrl_t;

  typedef struct packed {
    AxiResp_t resp;
  } AxiMasterRdStatus_t;

  typedef enum logic [2:0] {
    StIdle, StCalc, StAr, StR, StDone
  } AxiRdState_t;

  localparam int unsigned AXI_4KB = 4096;

  // Worst-case merge: DECERR > SLVERR > OKAY; EXOKAY is treated as OKAY.
  function automatic AxiResp_t axiWorstResp(AxiResp_t a, AxiResp_t b);
    if (a == RespDecerr || b == RespDecerr) return RespDecerr;
    if (a == RespSlverr || b == RespSlverr) return RespSlverr;
    return RespOkay;
  endfunction

  // Beats left before the next 4 KB boundary, given the low 12 address bits.
  function automatic logic [12:0] beatsTo4k(logic [11:0] addr_lo, AxiSize_t size);
    logic [12:0] bytes_left;
    bytes_left = 13'(AXI_4KB) - {1'b0, addr_lo};
    return bytes_left >> size;
  endfunction

endpackage

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-master sequencer: splits one job into 4 KB-safe INCR bursts, forwards R data
// downstream and reports a single accumulated response per job.
module axi_rd_burst_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BEATS = 256,
  parameter logic [3:0]  CACHE     = 4'b0011
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ctrl_valid_i,
  output logic              ctrl_ready_o,
  input  logic [47:0]       ctrl_i,
  output logic              status_valid_o,
  output logic [1:0]        status_o,
  output logic [31:0]       araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic [3:0]        arcache_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned ARSIZE     = $clog2(BEAT_BYTES);

  AxiMasterRdCtrl_t ctrl;
  assign ctrl = AxiMasterRdCtrl_t'(ctrl_i);

  AxiRdState_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [16:0] remaining_q, remaining_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  AxiResp_t    err_q, err_d;
  AxiResp_t    status_q, status_d;

  logic [16:0] total_beats;
  logic [12:0] beats_4k;
  logic [16:0] burst_beats;
  logic [8:0]  cur_beats;
  logic        unaligned;
  logic        in_r;
  logic        r_hs;
  logic        last_beat;
  logic        rlast_err;
  AxiResp_t    beat_resp;

  assign in_r      = (state_q == StR);
  assign r_hs      = rvalid_i & rready_o;
  assign last_beat = (beat_cnt_q == {1'b0, arlen_q});
  // rlast must coincide exactly with the beat we count as final.
  assign rlast_err = rlast_i ^ last_beat;
  assign beat_resp = axiWorstResp(AxiResp_t'(rresp_i), rlast_err ? RespSlverr : RespOkay);

  // Burst-split arithmetic: job length in beats and the size of the next burst.
  always_comb begin
    total_beats = 17'(({1'b0, ctrl.bytes} + 17'(BEAT_BYTES - 1)) >> ARSIZE);
    beats_4k    = beatsTo4k(addr_q[11:0], AxiSize_t'(3'(ARSIZE)));
    burst_beats = remaining_q;
    if (burst_beats > 17'(MAX_BEATS)) burst_beats = 17'(MAX_BEATS);
    if (burst_beats > 17'(beats_4k)) burst_beats = 17'(beats_4k);
    cur_beats   = {1'b0, arlen_q} + 9'd1;
    unaligned   = (addr_q & 32'(BEAT_BYTES - 1)) != '0;
  end

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    status_d    = status_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_valid_i) begin
          addr_d      = ctrl.address;
          remaining_d = total_beats;
          err_d       = RespOkay;
          state_d     = StCalc;
        end
      end
      StCalc: begin
        // Degenerate jobs are rejected here so they report with the same latency as a
        // normal job reaches AR.
        if (unaligned) begin
          err_d   = RespSlverr;
          state_d = StDone;
        end else if (remaining_q == '0) begin
          state_d = StDone;
        end else begin
          araddr_d   = addr_q;
          arlen_d    = 8'(burst_beats - 17'd1);
          beat_cnt_d = '0;
          state_d    = StAr;
        end
      end
      StAr: begin
        if (arready_i) state_d = StR;
      end
      StR: begin
        if (r_hs) begin
          err_d      = axiWorstResp(err_q, beat_resp);
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) begin
            addr_d      = addr_q + (32'(cur_beats) << ARSIZE);
            remaining_d = remaining_q - 17'(cur_beats);
            state_d     = (remaining_d == '0) ? StDone : StCalc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Capture the final response on entry to DONE so it is valid with the pulse.
    if (state_d == StDone && state_q != StDone) status_d = err_d;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= RespOkay;
      status_q    <= RespOkay;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      status_q    <= status_d;
    end
  end

  assign ctrl_ready_o   = (state_q == StIdle);
  assign status_valid_o = (state_q == StDone);
  assign status_o       = status_q;

  assign araddr_o  = araddr_q;
  assign arlen_o   = arlen_q;
  assign arsize_o  = 3'(ARSIZE);
  assign arburst_o = BurstIncr;
  assign arcache_o = CACHE;
  assign arvalid_o = (state_q == StAr);

  assign rready_o     = data_ready_i & in_r;
  assign data_o       = rdata_i;
  assign data_valid_o = rvalid_i & in_r;

endmodule
